// File: rtl/canvas_painter_if.sv
`default_nettype none
// ============================================================================
//  Module      : canvas_painter_if
//  Description : VRAM write port and VGA overlay path of the canvas painter.
//                The master side is the painter, the slave side is the
//                VRAM / VGA pixel pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface canvas_painter_if #(
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int CW = 12
);

  // VRAM write port
  logic                 vram_we;
  logic [XW+YW-1:0]     vram_wa;
  logic [CW-1:0]        vram_wd;

  // VGA overlay path
  logic                 pix_en;
  logic [XW-1:0]        pix_x;
  logic [YW-1:0]        pix_y;
  logic [CW-1:0]        vram_rd;
  logic [CW-1:0]        pix_rgb;

  modport master (
    output vram_we,
    output vram_wa,
    output vram_wd,
    output pix_rgb,
    input  pix_en,
    input  pix_x,
    input  pix_y,
    input  vram_rd
  );

  modport slave (
    input  vram_we,
    input  vram_wa,
    input  vram_wd,
    input  pix_rgb,
    output pix_en,
    output pix_x,
    output pix_y,
    output vram_rd
  );

endinterface
`default_nettype wire

// File: rtl/canvas_painter.sv
`default_nettype none
// ============================================================================
//  Module      : canvas_painter
//  Description : Cursor control with button auto-repeat, square brush
//                stamping and full-canvas clear for a VRAM-backed canvas,
//                plus the combinational cursor overlay for the VGA path.
//  Revision    : 1.0 - initial release
// ============================================================================
module canvas_painter #(
  parameter int XW     = 8,
  parameter int YW     = 8,
  parameter int CW     = 12,
  parameter int BW     = 3,
  parameter int HOLD   = 50_000_000,
  parameter int REPEAT = 4_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_l_i,
  input  logic             btn_u_i,
  input  logic             btn_r_i,
  input  logic             btn_d_i,
  input  logic             draw_i,
  input  logic             clear_i,
  input  logic [CW-1:0]    color_i,
  input  logic [BW-1:0]    brush_i,
  output logic [XW-1:0]    cur_x_o,
  output logic [YW-1:0]    cur_y_o,
  output logic             busy_o,
  canvas_painter_if.master bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Button counter only needs to reach the end of the first repeat window;
  // it then folds back to HOLD so pulses keep coming forever.
  localparam int c_cnt_w = $clog2(HOLD + REPEAT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_hold = c_cnt_w'(HOLD);
  localparam logic [c_cnt_w-1:0] c_cnt_wrap = c_cnt_w'(HOLD + REPEAT - 1);

  // Stamp target sums carry one extra bit so overflow past the canvas edge
  // is visible as a non-zero upper slice.
  localparam int c_sx_w = ((XW > BW) ? XW : BW) + 1;
  localparam int c_sy_w = ((YW > BW) ? YW : BW) + 1;

  localparam logic [XW-1:0] c_x_home = XW'((2 ** (XW - 1)) - 1);
  localparam logic [YW-1:0] c_y_home = YW'((2 ** (YW - 1)) - 1);
  localparam logic [XW-1:0] c_x_max  = '1;
  localparam logic [YW-1:0] c_y_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STAMP = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Button auto-repeat: one counter per button, bit order {l, u, r, d}
  // --------------------------------------------------------------------------
  logic [3:0] w_btn;
  logic [3:0] w_pulse;

  assign w_btn = {btn_l_i, btn_u_i, btn_r_i, btn_d_i};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // Count held cycles; fold the repeat window back onto HOLD.
    always_comb begin
      cnt_d = '0;
      if (w_btn[gi]) begin
        if (cnt_q == c_cnt_wrap) begin
          cnt_d = c_cnt_hold;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
    end

    // Counter register.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // First-press pulse, then one pulse per repeat period after HOLD.
    assign w_pulse[gi] = (cnt_q == c_cnt_one) || (cnt_q == c_cnt_hold);
  end

  // --------------------------------------------------------------------------
  // Painter state
  // --------------------------------------------------------------------------
  state_t              state_q,  state_d;
  logic [XW-1:0]       cur_x_q,  cur_x_d;
  logic [YW-1:0]       cur_y_q,  cur_y_d;
  logic [XW-1:0]       x0_q,     x0_d;
  logic [YW-1:0]       y0_q,     y0_d;
  logic [BW-1:0]       size_q,   size_d;
  logic [BW-1:0]       dx_q,     dx_d;
  logic [BW-1:0]       dy_q,     dy_d;
  logic [CW-1:0]       col_q,    col_d;
  logic [XW+YW-1:0]    clr_a_q,  clr_a_d;
  logic                we_q,     we_d;
  logic [XW+YW-1:0]    wa_q,     wa_d;
  logic [CW-1:0]       wd_q,     wd_d;

  // Current stamp pixel and whether it falls inside the canvas.
  logic [c_sx_w-1:0]   w_sx;
  logic [c_sy_w-1:0]   w_sy;
  logic                w_in_canvas;
  logic                w_dx_last;
  logic                w_dy_last;

  assign w_sx        = c_sx_w'(x0_q) + c_sx_w'(dx_q);
  assign w_sy        = c_sy_w'(y0_q) + c_sy_w'(dy_q);
  assign w_in_canvas = (w_sx[c_sx_w-1:XW] == '0) && (w_sy[c_sy_w-1:YW] == '0);
  assign w_dx_last   = (dx_q == size_q - BW'(1));
  assign w_dy_last   = (dy_q == size_q - BW'(1));

  // Next-state, cursor movement and write-port generation.
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    size_d  = size_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    col_d   = col_q;
    clr_a_d = clr_a_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;

    case (state_q)
      S_IDLE: begin
        // Left beats right and up beats down; a losing pulse is dropped
        // even if the winner is blocked by the canvas edge.
        if (w_pulse[3]) begin
          if (cur_x_q != '0) cur_x_d = cur_x_q - XW'(1);
        end else if (w_pulse[1]) begin
          if (cur_x_q != c_x_max) cur_x_d = cur_x_q + XW'(1);
        end
        if (w_pulse[2]) begin
          if (cur_y_q != '0) cur_y_d = cur_y_q - YW'(1);
        end else if (w_pulse[0]) begin
          if (cur_y_q != c_y_max) cur_y_d = cur_y_q + YW'(1);
        end

        if (clear_i) begin
          col_d   = color_i;
          clr_a_d = '0;
          state_d = S_CLEAR;
        end else if (draw_i) begin
          x0_d    = cur_x_q;
          y0_d    = cur_y_q;
          size_d  = (brush_i == '0) ? BW'(1) : brush_i;
          col_d   = color_i;
          dx_d    = '0;
          dy_d    = '0;
          state_d = S_STAMP;
        end
      end

      S_STAMP: begin
        // Clipped pixels still take their cycle so a stamp is always
        // size*size cycles long.
        if (w_in_canvas) begin
          we_d = 1'b1;
          wa_d = {w_sx[XW-1:0], w_sy[YW-1:0]};
          wd_d = col_q;
        end
        if (w_dx_last) begin
          dx_d = '0;
          if (w_dy_last) begin
            state_d = S_IDLE;
          end else begin
            dy_d = dy_q + BW'(1);
          end
        end else begin
          dx_d = dx_q + BW'(1);
        end
      end

      S_CLEAR: begin
        we_d    = 1'b1;
        wa_d    = clr_a_q;
        wd_d    = col_q;
        clr_a_d = clr_a_q + (XW+YW)'(1);
        if (clr_a_q == '1) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, cursor and write-port registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_x_q <= c_x_home;
      cur_y_q <= c_y_home;
      x0_q    <= '0;
      y0_q    <= '0;
      size_q  <= BW'(1);
      dx_q    <= '0;
      dy_q    <= '0;
      col_q   <= '0;
      clr_a_q <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      size_q  <= size_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      col_q   <= col_d;
      clr_a_q <= clr_a_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign cur_x_o     = cur_x_q;
  assign cur_y_o     = cur_y_q;
  assign busy_o      = (state_q != S_IDLE);
  assign bus.vram_we = we_q;
  assign bus.vram_wa = wa_q;
  assign bus.vram_wd = wd_q;

  // Cursor overlay: blank outside the canvas, white under the cursor.
  always_comb begin
    bus.pix_rgb = '0;
    if (bus.pix_en) begin
      if ((bus.pix_x == cur_x_q) && (bus.pix_y == cur_y_q)) begin
        bus.pix_rgb = '1;
      end else begin
        bus.pix_rgb = bus.vram_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_canvas_painter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_canvas_painter
//  Description : Scoreboard bench for canvas_painter. DUT A is a 256x256
//                canvas, DUT B a 4x4 canvas used for clears and clipping.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_canvas_painter;

  localparam int CW  = 12;
  localparam int BW  = 3;
  localparam int XWA = 8;
  localparam int YWA = 8;
  localparam int XWB = 2;
  localparam int YWB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst;
  logic [1:0][3:0]     btn;      // {l, u, r, d}
  logic [1:0]          draw;
  logic [1:0]          clear;
  logic [1:0][CW-1:0]  color;
  logic [1:0][BW-1:0]  brush;
  logic [XWA-1:0]      cxa;
  logic [YWA-1:0]      cya;
  logic [XWB-1:0]      cxb;
  logic [YWB-1:0]      cyb;
  logic                busy_a;
  logic                busy_b;

  canvas_painter_if #(.XW(XWA), .YW(YWA), .CW(CW)) bus_a ();
  canvas_painter_if #(.XW(XWB), .YW(YWB), .CW(CW)) bus_b ();

  canvas_painter #(.XW(XWA), .YW(YWA), .CW(CW), .BW(BW), .HOLD(10), .REPEAT(4)) u_dut_a (
    .clk(clk), .rst(rst[0]),
    .btn_l_i(btn[0][3]), .btn_u_i(btn[0][2]), .btn_r_i(btn[0][1]), .btn_d_i(btn[0][0]),
    .draw_i(draw[0]), .clear_i(clear[0]), .color_i(color[0]), .brush_i(brush[0]),
    .cur_x_o(cxa), .cur_y_o(cya), .busy_o(busy_a), .bus(bus_a)
  );

  canvas_painter #(.XW(XWB), .YW(YWB), .CW(CW), .BW(BW), .HOLD(3), .REPEAT(2)) u_dut_b (
    .clk(clk), .rst(rst[1]),
    .btn_l_i(btn[1][3]), .btn_u_i(btn[1][2]), .btn_r_i(btn[1][1]), .btn_d_i(btn[1][0]),
    .draw_i(draw[1]), .clear_i(clear[1]), .color_i(color[1]), .brush_i(brush[1]),
    .cur_x_o(cxb), .cur_y_o(cyb), .busy_o(busy_b), .bus(bus_b)
  );

  // Reference model state
  int tests  = 0;
  int failed = 0;
  int mx[2];
  int my[2];
  int xmax[2]   = '{255, 3};
  int ymax[2]   = '{255, 3};
  int hold_p[2] = '{10, 3};
  int rep_p[2]  = '{4, 2};
  int ywv[2]    = '{YWA, YWB};
  int xwv[2]    = '{XWA, XWB};
  int qa[$];
  int qb[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cx(input int s);
    return (s == 0) ? int'(cxa) : int'(cxb);
  endfunction

  function automatic int cy(input int s);
    return (s == 0) ? int'(cya) : int'(cyb);
  endfunction

  function automatic logic bsy(input int s);
    return (s == 0) ? busy_a : busy_b;
  endfunction

  // Number of move pulses produced by a button held for n cycles.
  function automatic int npulses(input int s, input int n);
    int p = 0;
    for (int k = 1; k <= n; k++) begin
      if (k == 1 || (k >= hold_p[s] && (k - hold_p[s]) % rep_p[s] == 0)) p++;
    end
    return p;
  endfunction

  function automatic int hold_for(input int s, input int d);
    int n = 1;
    while (npulses(s, n) < d) n++;
    return n;
  endfunction

  task automatic push(input int s, input int x, input int y, input int col);
    int v;
    v = (((x << ywv[s]) | y) << CW) | col;
    if (s == 0) qa.push_back(v);
    else        qb.push_back(v);
  endtask

  task automatic move(input int s, input logic [3:0] m, input int n);
    int p;
    btn[s] = m;
    repeat (n) tick();
    btn[s] = '0;
    repeat (3) tick();
    p = npulses(s, n);
    if (m[3])      mx[s] = (mx[s] - p < 0) ? 0 : mx[s] - p;
    else if (m[1]) mx[s] = (mx[s] + p > xmax[s]) ? xmax[s] : mx[s] + p;
    if (m[2])      my[s] = (my[s] - p < 0) ? 0 : my[s] - p;
    else if (m[0]) my[s] = (my[s] + p > ymax[s]) ? ymax[s] : my[s] + p;
    check("cur_x", cx(s), mx[s]);
    check("cur_y", cy(s), my[s]);
  endtask

  task automatic move_to(input int s, input int x, input int y);
    if (x < mx[s])      move(s, 4'b1000, hold_for(s, mx[s] - x));
    else if (x > mx[s]) move(s, 4'b0010, hold_for(s, x - mx[s]));
    if (y < my[s])      move(s, 4'b0100, hold_for(s, my[s] - y));
    else if (y > my[s]) move(s, 4'b0001, hold_for(s, y - my[s]));
  endtask

  task automatic busy_count(input int s, input int bound, output int cnt);
    cnt = 0;
    while (bsy(s) && cnt < bound) begin
      cnt++;
      tick();
    end
  endtask

  task automatic stamp(input int s, input int b, input int col);
    int sz;
    int cnt;
    sz = (b == 0) ? 1 : b;
    for (int dy = 0; dy < sz; dy++)
      for (int dx = 0; dx < sz; dx++)
        if (mx[s] + dx <= xmax[s] && my[s] + dy <= ymax[s])
          push(s, mx[s] + dx, my[s] + dy, col);
    color[s] = CW'(col);
    brush[s] = BW'(b);
    draw[s]  = 1'b1;
    tick();
    draw[s]  = 1'b0;
    busy_count(s, sz * sz + 20, cnt);
    check("stamp_busy", cnt, sz * sz);
  endtask

  task automatic clr(input int s, input int col, input logic with_draw);
    int n;
    int cnt;
    n = 1 << (xwv[s] + ywv[s]);
    for (int a = 0; a < n; a++) push(s, a >> ywv[s], a & ((1 << ywv[s]) - 1), col);
    color[s] = CW'(col);
    clear[s] = 1'b1;
    draw[s]  = with_draw;
    tick();
    clear[s] = 1'b0;
    draw[s]  = 1'b0;
    busy_count(s, n + 20, cnt);
    check("clear_busy", cnt, n);
  endtask

  task automatic random_ops(input int s, input int nops);
    int op;
    for (int i = 0; i < nops; i++) begin
      op = (s == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
      case (op)
        0:       move(s, 4'($urandom_range(1, 15)), int'($urandom_range(1, 25)));
        1:       stamp(s, int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
        default: clr(s, int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  // Scoreboard monitors: every VRAM write must match the oldest expectation.
  always @(negedge clk) begin
    if (bus_a.vram_we === 1'b1) begin
      if (qa.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL write_a: unexpected write wa=0x%0h wd=0x%0h required none",
                 bus_a.vram_wa, bus_a.vram_wd);
      end else begin
        check("write_a", int'({bus_a.vram_wa, bus_a.vram_wd}), qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.vram_we === 1'b1) begin
      if (qb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL write_b: unexpected write wa=0x%0h wd=0x%0h required none",
                 bus_b.vram_wa, bus_b.vram_wd);
      end else begin
        check("write_b", int'({bus_b.vram_wa, bus_b.vram_wd}), qb.pop_front());
      end
    end
  end

  initial begin
    int k;
    int guard;
    int rd;

    rst   = 2'b11;
    btn   = '0;
    draw  = '0;
    clear = '0;
    color = '0;
    brush = '0;
    bus_a.pix_en = 1'b0; bus_a.pix_x = '0; bus_a.pix_y = '0; bus_a.vram_rd = '0;
    bus_b.pix_en = 1'b0; bus_b.pix_x = '0; bus_b.pix_y = '0; bus_b.vram_rd = '0;
    tick();
    tick();
    rst = 2'b00;
    mx = '{127, 1};
    my = '{127, 1};

    // Reset state
    check("rst_cur_x", int'(cxa), 127);
    check("rst_cur_y", int'(cya), 127);
    check("rst_busy", int'(busy_a), 0);
    check("rst_we", int'(bus_a.vram_we), 0);
    check("rst_wa", int'(bus_a.vram_wa), 0);
    check("rst_wd", int'(bus_a.vram_wd), 0);
    check("rst_b_cur_x", int'(cxb), 1);
    check("rst_b_cur_y", int'(cyb), 1);

    // Auto-repeat and clamping on the large canvas
    move(0, 4'b0010, 1);      // 127 -> 128
    move(0, 4'b1000, 1);      // back to 127
    move(0, 4'b0010, 30);     // seven pulses -> 134
    move(0, 4'b1000, 600);    // clamps at 0
    move(0, 4'b1000, 3);
    move(0, 4'b0010, 1100);   // clamps at 255
    move(0, 4'b0010, 2);
    move(0, 4'b1010, 5);      // left beats right -> 254
    move(0, 4'b0101, 1);      // up beats down

    // Brush stamps
    move_to(0, 10, 20);
    stamp(0, 3, 'hF00);
    move_to(0, 254, 255);
    stamp(0, 3, 'h0F0);       // seven of nine pixels clipped
    stamp(0, 0, 'h00F);       // brush 0 behaves as 1

    // Overlay
    rd = int'($urandom_range(0, 4094));
    bus_a.vram_rd = CW'(rd);
    bus_a.pix_en  = 1'b1;
    bus_a.pix_x   = XWA'(mx[0]);
    bus_a.pix_y   = YWA'(my[0]);
    #1 check("ovl_cursor", int'(bus_a.pix_rgb), 'hFFF);
    bus_a.pix_x   = XWA'(mx[0] ^ 1);
    #1 check("ovl_x_off", int'(bus_a.pix_rgb), rd);
    bus_a.pix_x   = XWA'(mx[0]);
    bus_a.pix_y   = YWA'(my[0] ^ 4);
    #1 check("ovl_y_off", int'(bus_a.pix_rgb), rd);
    bus_a.pix_y   = YWA'(my[0]);
    bus_a.pix_en  = 1'b0;
    #1 check("ovl_disabled", int'(bus_a.pix_rgb), 0);

    random_ops(0, 10);

    // Small canvas: clear beats draw, then reset mid-clear
    clr(1, 'h0A5, 1'b1);
    check("clr_cur_x", int'(cxb), mx[1]);

    for (int a = 0; a < 16; a++) push(1, a >> YWB, a & 3, 'h5A0);
    color[1] = CW'('h5A0);
    clear[1] = 1'b1;
    tick();
    clear[1] = 1'b0;
    k = 0;
    guard = 0;
    while (k < 5 && guard < 50) begin
      @(negedge clk);
      if (bus_b.vram_we === 1'b1) k++;
      guard++;
    end
    check("abort_reached_write5", k, 5);
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    qb.delete();
    mx[1] = 1;
    my[1] = 1;
    check("abort_we", int'(bus_b.vram_we), 0);
    check("abort_busy", int'(busy_b), 0);
    check("abort_cur_x", int'(cxb), 1);
    check("abort_cur_y", int'(cyb), 1);
    repeat (3) tick();

    move_to(1, 2, 3);
    stamp(1, 3, 'h123);       // clipped at both edges
    random_ops(1, 30);

    repeat (5) tick();
    check("pending_a", qa.size(), 0);
    check("pending_b", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
